// File: rtl/ps2_device_tx.sv
// PS/2 device-side transmitter: frames a byte as start/8 data/odd parity/stop,
// generates the PS/2 clock itself and backs off when the host holds the clock low.
module ps2_device_tx #(
  parameter int QUARTER = 2500,
  parameter int GAP     = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2c_in,
  output logic       ps2c,
  output logic       ps2d,
  output logic       tx_busy,
  output logic       tx_done_tick,
  output logic       tx_abort_tick
);

  localparam int QW = $clog2(QUARTER) + 2;
  localparam int GW = $clog2(GAP + 1);
  localparam logic [QW-1:0] HALF    = QW'(2 * QUARTER);
  localparam logic [QW-1:0] HALF_M1 = QW'(2 * QUARTER - 1);
  localparam logic [QW-1:0] LAST    = QW'(4 * QUARTER - 1);
  localparam logic [GW-1:0] GAP_M1  = GW'(GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SEND,
    S_GAP
  } state_t;

  state_t          state_q, state_d;
  logic [QW-1:0]   qcnt_q, qcnt_d;
  logic [3:0]      bit_q, bit_d;
  logic [GW-1:0]   gcnt_q, gcnt_d;
  logic [10:0]     frame_q, frame_d;
  logic            ps2c_q, ps2c_d;
  logic            ps2d_q, ps2d_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            abort_q, abort_d;
  logic            meta_q, meta_d;
  logic            sync_q, sync_d;
  logic            c_h1_q, c_h1_d;
  logic            c_h2_q, c_h2_d;
  logic [QW-1:0]   qcnt_nx;
  logic [3:0]      bit_nx;

  always_comb begin
    state_d = state_q;
    qcnt_d  = qcnt_q;
    bit_d   = bit_q;
    gcnt_d  = gcnt_q;
    frame_d = frame_q;
    ps2c_d  = ps2c_q;
    ps2d_d  = ps2d_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    abort_d = 1'b0;
    meta_d  = ps2c_in;
    sync_d  = meta_q;
    c_h1_d  = ps2c_q;
    c_h2_d  = c_h1_q;
    qcnt_nx = qcnt_q + QW'(1);
    bit_nx  = bit_q + 4'd1;

    case (state_q)
      S_IDLE: begin
        if (tx_start) begin
          frame_d = {1'b1, ~^tx_data, tx_data, 1'b0};
          busy_d  = 1'b1;
          qcnt_d  = '0;
          bit_d   = '0;
          if (sync_q) begin
            state_d = S_SEND;
            ps2c_d  = 1'b1;
            ps2d_d  = 1'b0;
          end else begin
            state_d = S_WAIT;
          end
        end
      end

      // Host is inhibiting: qcnt counts consecutive released-clock cycles.
      S_WAIT: begin
        if (!sync_q) begin
          qcnt_d = '0;
        end else if (qcnt_q == HALF_M1) begin
          state_d = S_SEND;
          qcnt_d  = '0;
          ps2c_d  = 1'b1;
          ps2d_d  = 1'b0;
        end else begin
          qcnt_d = qcnt_nx;
        end
      end

      S_SEND: begin
        // The synchronised line lags our drive by two cycles, so only a low
        // seen while our own drive was high two cycles ago is the host.
        if (qcnt_q < HALF && c_h2_q && !sync_q) begin
          state_d = S_IDLE;
          ps2c_d  = 1'b1;
          ps2d_d  = 1'b1;
          busy_d  = 1'b0;
          abort_d = 1'b1;
          qcnt_d  = '0;
          bit_d   = '0;
        end else if (qcnt_q == LAST) begin
          qcnt_d = '0;
          ps2c_d = 1'b1;
          if (bit_q == 4'd10) begin
            state_d = S_GAP;
            ps2d_d  = 1'b1;
            gcnt_d  = '0;
            bit_d   = '0;
          end else begin
            bit_d  = bit_nx;
            ps2d_d = frame_q[bit_nx];
          end
        end else begin
          qcnt_d = qcnt_nx;
          ps2c_d = (qcnt_nx < HALF);
        end
      end

      S_GAP: begin
        if (gcnt_q == GAP_M1) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          gcnt_d  = '0;
        end else begin
          gcnt_d = gcnt_q + GW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      qcnt_q  <= '0;
      bit_q   <= '0;
      gcnt_q  <= '0;
      frame_q <= '0;
      ps2c_q  <= 1'b1;
      ps2d_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      c_h1_q  <= 1'b1;
      c_h2_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      qcnt_q  <= qcnt_d;
      bit_q   <= bit_d;
      gcnt_q  <= gcnt_d;
      frame_q <= frame_d;
      ps2c_q  <= ps2c_d;
      ps2d_q  <= ps2d_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      abort_q <= abort_d;
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      c_h1_q  <= c_h1_d;
      c_h2_q  <= c_h2_d;
    end
  end

  assign ps2c          = ps2c_q;
  assign ps2d          = ps2d_q;
  assign tx_busy       = busy_q;
  assign tx_done_tick  = done_q;
  assign tx_abort_tick = abort_q;

endmodule
